// File: rtl/register_bank_pkg.sv
// Shared constants and helpers for the register bank and its storage rows.
package register_bank_pkg;

  localparam int LANE_W = 8;

  // Address width for a given depth; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Number of byte lanes in a word of the given width.
  function automatic int lane_count(input int width);
    return width / LANE_W;
  endfunction

endpackage

// File: rtl/byte_reg_row.sv
// One register entry with independent byte-lane write enables.
module byte_reg_row
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [lane_count(WIDTH)-1:0] en,
  input  logic [WIDTH-1:0]             d,
  output logic [WIDTH-1:0]             q
);

  localparam int LANES = lane_count(WIDTH);

  // Each enabled lane captures its byte of d; disabled lanes hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (en[k]) q[k*LANE_W +: LANE_W] <= d[k*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/register_bank.sv
// Multi-port register file: byte-lane writes, optional hardwired-zero entry 0,
// same-cycle write-to-read bypass and a per-entry pending-write scoreboard.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = addr_width(DEPTH),
  localparam int LANES   = lane_count(WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [LANES-1:0]       wr_be,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  output logic                   wr_unres
);

  // An address is usable when it names a real entry that is not the hardwired zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  logic             wr_ok;
  logic             rsv_ok;
  logic [DEPTH-1:0] wr_sel;
  logic [DEPTH-1:0] rsv_sel;
  logic [DEPTH-1:0] pending;
  logic [WIDTH-1:0] mem [DEPTH];

  assign wr_ok  = wr_en  && addr_ok(wr_addr);
  assign rsv_ok = rsv_en && addr_ok(rsv_addr);

  // One-hot decode of the write and reserve targets.
  always_comb begin
    wr_sel  = '0;
    rsv_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel[i]  = wr_ok  && (wr_addr  == AW'(i));
      rsv_sel[i] = rsv_ok && (rsv_addr == AW'(i));
    end
  end

  // Storage rows; entry 0 is a constant when it is the hardwired zero.
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    if (ZERO_REG && i == 0) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_store
      byte_reg_row #(.WIDTH(WIDTH)) u_row (
        .clk   (clk),
        .reset (reset),
        .en    (wr_sel[i] ? wr_be : '0),
        .d     (wr_data),
        .q     (mem[i])
      );
    end
  end

  // Pending bits: a reserve sets, a write clears, and a reserve wins a same-entry tie
  // so a back-to-back producer keeps the entry marked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rsv_sel[i])     pending[i] <= 1'b1;
        else if (wr_sel[i]) pending[i] <= 1'b0;
      end
    end
  end

  // Diagnostic: flag a write to an entry nobody reserved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_unres <= 1'b0;
    else        wr_unres <= wr_ok && ((wr_sel & pending) == '0);
  end

  // Read ports: combinational mux, lane-merged bypass and busy derivation.
  // The bypass is suppressed while reset is held because that write never lands.
  for (genvar p = 0; p < NREAD; p++) begin : g_port
    logic [AW-1:0]    addr;
    logic             ok;
    logic             hit;
    logic             pend;
    logic [WIDTH-1:0] stored;
    logic [WIDTH-1:0] merged;

    assign addr = rd_addr[p*AW +: AW];
    assign ok   = addr_ok(addr);
    assign hit  = BYPASS && reset && wr_ok && (wr_addr == addr);

    // Select the stored word and its pending bit for this port.
    always_comb begin
      stored = '0;
      pend   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (addr == AW'(i)) begin
          stored = mem[i];
          pend   = pending[i];
        end
      end
    end

    // Enabled lanes come from the in-flight write, the rest from storage.
    always_comb begin
      merged = stored;
      for (int k = 0; k < LANES; k++) begin
        if (wr_be[k]) merged[k*LANE_W +: LANE_W] = wr_data[k*LANE_W +: LANE_W];
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = !ok ? '0 : (hit ? merged : stored);
    assign rd_busy[p]                = ok && pend && !hit;
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: four parameter variants share one stimulus stream,
// expectations are queued by the stimulus and checked by a negedge monitor.
module tb_register_bank;

  localparam int W  = 32;
  localparam int AW = 5;

  localparam int K_RD0       = 0;
  localparam int K_RD1       = 1;
  localparam int K_BUSY      = 2;
  localparam int K_UNRES     = 3;
  localparam int K_NB_RD0    = 4;
  localparam int K_NB_RD1    = 5;
  localparam int K_NB_BUSY   = 6;
  localparam int K_NZ_RD0    = 7;
  localparam int K_NZ_BUSY   = 8;
  localparam int K_D24_RD0   = 9;
  localparam int K_D24_BUSY  = 10;
  localparam int K_D24_UNRES = 11;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [3:0]    wr_be;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic [2*AW-1:0] rd_addr;

  logic [2*W-1:0] rd_data_m, rd_data_nb, rd_data_nz, rd_data_d24;
  logic [1:0]     busy_m, busy_nb, busy_nz, busy_d24;
  logic           unres_m, unres_nb, unres_nz, unres_d24;

  logic [W-1:0] exp_q[$];
  int           kind_q[$];
  string        name_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  register_bank #(.DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_main (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(rd_data_m), .rd_busy(busy_m), .wr_unres(unres_m));

  register_bank #(.DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .rd_busy(busy_nb), .wr_unres(unres_nb));

  register_bank #(.DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_nz (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(rd_data_nz), .rd_busy(busy_nz), .wr_unres(unres_nz));

  register_bank #(.DEPTH(24), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_d24 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(rd_data_d24), .rd_busy(busy_d24), .wr_unres(unres_d24));

  function automatic logic [W-1:0] obs(input int k);
    case (k)
      K_RD0:       return rd_data_m[0 +: W];
      K_RD1:       return rd_data_m[W +: W];
      K_BUSY:      return {30'd0, busy_m};
      K_UNRES:     return {31'd0, unres_m};
      K_NB_RD0:    return rd_data_nb[0 +: W];
      K_NB_RD1:    return rd_data_nb[W +: W];
      K_NB_BUSY:   return {30'd0, busy_nb};
      K_NZ_RD0:    return rd_data_nz[0 +: W];
      K_NZ_BUSY:   return {30'd0, busy_nz};
      K_D24_RD0:   return rd_data_d24[0 +: W];
      K_D24_BUSY:  return {30'd0, busy_d24};
      K_D24_UNRES: return {31'd0, unres_d24};
      default:     return 'x;
    endcase
  endfunction

  // Driver tasks
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic [3:0] be, input logic re, input logic [AW-1:0] ra,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    wr_be    = be;
    rsv_en   = re;
    rsv_addr = ra;
    rd_addr  = {a1, a0};
  endtask

  task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    drive(1'b0, '0, '0, 4'h0, 1'b0, '0, a0, a1);
  endtask

  task automatic expect_val(input int k, input logic [W-1:0] v, input string n);
    exp_q.push_back(v);
    kind_q.push_back(k);
    name_q.push_back(n);
  endtask

  // Let the monitor sample at the negedge, then commit at the posedge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: drains all queued expectations against settled outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      int           k;
      string        n;
      e = exp_q.pop_front();
      k = kind_q.pop_front();
      n = name_q.pop_front();
      a = obs(k);
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    idle(5'd5, 5'd6);
    expect_val(K_RD0, 32'h0, "init_rd0");
    expect_val(K_BUSY, 32'h0, "init_busy");
    expect_val(K_UNRES, 32'h0, "init_unres");
    step();
    reset = 1'b1;

    // Byte lanes with bypass and without
    drive(1'b1, 5'd5, 32'hFFFF_FFFF, 4'hF, 1'b0, '0, 5'd5, 5'd5);
    expect_val(K_RD0, 32'hFFFF_FFFF, "lane_full_bypass");
    expect_val(K_NB_RD0, 32'h0, "lane_full_nobypass");
    step();
    drive(1'b1, 5'd5, 32'h1234_5678, 4'b0101, 1'b0, '0, 5'd5, 5'd5);
    expect_val(K_RD0, 32'hFF34_FF78, "lane_part_bypass");
    expect_val(K_NB_RD0, 32'hFFFF_FFFF, "lane_part_nobypass");
    expect_val(K_UNRES, 32'h1, "unres_after_w1");
    step();
    idle(5'd5, 5'd5);
    expect_val(K_RD0, 32'hFF34_FF78, "lane_stored");
    expect_val(K_NB_RD1, 32'hFF34_FF78, "lane_stored_nb");
    step();

    // Bypass merge on both ports
    drive(1'b1, 5'd7, 32'hAAAA_AAAA, 4'hF, 1'b0, '0, 5'd3, 5'd3);
    expect_val(K_UNRES, 32'h0, "unres_after_idle");
    step();
    drive(1'b1, 5'd7, 32'h5555_5555, 4'b0011, 1'b0, '0, 5'd7, 5'd7);
    expect_val(K_RD0, 32'hAAAA_5555, "bypass_p0");
    expect_val(K_RD1, 32'hAAAA_5555, "bypass_p1");
    expect_val(K_NB_RD0, 32'hAAAA_AAAA, "nobypass_p0");
    expect_val(K_NB_RD1, 32'hAAAA_AAAA, "nobypass_p1");
    step();
    idle(5'd7, 5'd7);
    expect_val(K_NB_RD0, 32'hAAAA_5555, "nobypass_next");
    expect_val(K_RD1, 32'hAAAA_5555, "bypass_stored");
    step();

    // Zero register
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 4'hF, 1'b1, 5'd0, 5'd0, 5'd0);
    expect_val(K_RD0, 32'h0, "zero_bypass");
    expect_val(K_BUSY, 32'h0, "zero_busy_now");
    expect_val(K_NZ_RD0, 32'hDEAD_BEEF, "nz_bypass");
    step();
    idle(5'd0, 5'd0);
    expect_val(K_RD0, 32'h0, "zero_stored");
    expect_val(K_BUSY, 32'h0, "zero_busy");
    expect_val(K_UNRES, 32'h0, "zero_unres");
    expect_val(K_NZ_RD0, 32'hDEAD_BEEF, "nz_stored");
    expect_val(K_NZ_BUSY, 32'h3, "nz_busy");
    step();

    // Scoreboard
    drive(1'b0, '0, '0, 4'h0, 1'b1, 5'd3, 5'd3, 5'd3);
    expect_val(K_BUSY, 32'h0, "rsv_same_cycle");
    step();
    idle(5'd3, 5'd3);
    expect_val(K_BUSY, 32'h3, "rsv_next_cycle");
    step();
    drive(1'b1, 5'd3, 32'hCAFE_F00D, 4'hF, 1'b1, 5'd3, 5'd3, 5'd4);
    expect_val(K_RD0, 32'hCAFE_F00D, "wr_rsv_bypass");
    expect_val(K_BUSY, 32'h0, "wr_rsv_bypass_busy");
    expect_val(K_NB_BUSY, 32'h1, "wr_rsv_nb_busy");
    expect_val(K_NB_RD0, 32'h0, "wr_rsv_nb_rd");
    step();
    idle(5'd3, 5'd3);
    expect_val(K_BUSY, 32'h3, "rsv_wins");
    expect_val(K_RD0, 32'hCAFE_F00D, "wr_rsv_data");
    expect_val(K_UNRES, 32'h0, "unres_reserved");
    step();
    drive(1'b1, 5'd3, 32'h0, 4'h0, 1'b0, '0, 5'd3, 5'd3);
    expect_val(K_RD0, 32'hCAFE_F00D, "be0_bypass");
    expect_val(K_BUSY, 32'h0, "be0_bypass_busy");
    expect_val(K_NB_BUSY, 32'h3, "be0_nb_busy");
    step();
    idle(5'd3, 5'd3);
    expect_val(K_BUSY, 32'h0, "write_clears");
    expect_val(K_RD0, 32'hCAFE_F00D, "be0_keeps");
    expect_val(K_UNRES, 32'h0, "unres_cleared_pending");
    step();

    // Unreserved write pulse
    drive(1'b1, 5'd9, 32'h0000_0009, 4'hF, 1'b0, '0, 5'd9, 5'd9);
    step();
    idle(5'd9, 5'd9);
    expect_val(K_UNRES, 32'h1, "unres_pulse");
    step();
    idle(5'd9, 5'd9);
    expect_val(K_UNRES, 32'h0, "unres_drop");
    expect_val(K_RD1, 32'h0000_0009, "r9_stored");
    step();

    // Out-of-range address with DEPTH=24
    drive(1'b1, 5'd30, 32'h1212_1212, 4'hF, 1'b1, 5'd30, 5'd30, 5'd30);
    expect_val(K_D24_RD0, 32'h0, "d24_bypass");
    expect_val(K_D24_BUSY, 32'h0, "d24_busy_now");
    expect_val(K_RD0, 32'h1212_1212, "r30_bypass");
    step();
    idle(5'd30, 5'd30);
    expect_val(K_D24_RD0, 32'h0, "d24_stored");
    expect_val(K_D24_BUSY, 32'h0, "d24_busy");
    expect_val(K_D24_UNRES, 32'h0, "d24_unres");
    expect_val(K_RD0, 32'h1212_1212, "r30_stored");
    step();

    // Reset asserted mid-cycle during a write and reserve
    drive(1'b1, 5'd5, 32'h7777_7777, 4'hF, 1'b1, 5'd5, 5'd5, 5'd9);
    #2;
    reset = 1'b0;
    #1;
    expect_val(K_RD0, 32'h0, "rst_rd0");
    expect_val(K_RD1, 32'h0, "rst_rd1");
    expect_val(K_BUSY, 32'h0, "rst_busy");
    expect_val(K_UNRES, 32'h0, "rst_unres");
    expect_val(K_NB_RD0, 32'h0, "rst_nb_rd0");
    step();
    reset = 1'b1;
    idle(5'd5, 5'd9);
    expect_val(K_RD0, 32'h0, "post_rst_rd0");
    expect_val(K_RD1, 32'h0, "post_rst_rd1");
    expect_val(K_BUSY, 32'h0, "post_rst_busy");
    step();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
